// File: rtl/timer_ctrl.sv
// Start/stop period timer with prescaler, one-shot or auto-reload, terminal tick and sticky irq.
// Latency: tick rises the cycle after the terminal advance; all outputs registered except busy.
// Backpressure: none; start/stop/irq_clr are single-cycle pulses, config is captured only on start.
module timer_ctrl #(
  parameter int N  = 8,
  parameter int PW = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic          periodic,
  input  logic [N-1:0]  period,
  input  logic [PW-1:0] prescale,
  input  logic          irq_clr,
  output logic [N-1:0]  cnt,
  output logic          busy,
  output logic          tick,
  output logic          irq,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  cnt_q, cnt_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [N-1:0]  period_q, period_d;
  logic [PW-1:0] prescale_q, prescale_d;
  logic          periodic_q, periodic_d;
  logic          tick_q, tick_d;
  logic          irq_q, irq_d;

  // Next-state: stop beats start, start beats counting; only RUN advances the count.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    periodic_d = periodic_q;
    tick_d     = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      pc_d    = '0;
    end else if (start) begin
      state_d    = ST_RUN;
      cnt_d      = '0;
      pc_d       = '0;
      period_d   = period;
      prescale_d = prescale;
      periodic_d = periodic;
    end else if (state_q == ST_RUN) begin
      if (pc_q != prescale_q) begin
        pc_d = pc_q + 1'b1;
      end else begin
        // Prescaler wrapped: this edge is an advance of the main count.
        pc_d = '0;
        if (cnt_q != period_q) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          tick_d = 1'b1;
          if (periodic_q) begin
            cnt_d = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
    end

    // The irq set term covers both the terminal edge and the cycle tick is
    // visible, so a clear that coincides with a visible tick still loses.
    irq_d = tick_d | tick_q | (irq_q & ~irq_clr);
  end

  // State and datapath registers; reset aborts any run without emitting a tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pc_q       <= '0;
      period_q   <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
      tick_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      periodic_q <= periodic_d;
      tick_q     <= tick_d;
      irq_q      <= irq_d;
    end
  end

  assign cnt   = cnt_q;
  assign tick  = tick_q;
  assign irq   = irq_q;
  assign state = state_q;
  assign busy  = (state_q == ST_RUN);

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: expected tick edges are queued when start is driven and
// compared every cycle; register-visible values are checked at the falling edge.
// No backpressure in the DUT; the bench drives inputs at the falling edge only.
module tb_timer_ctrl;
  localparam int N  = 4;
  localparam int PW = 4;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic          stop;
  logic          periodic;
  logic [N-1:0]  period;
  logic [PW-1:0] prescale;
  logic          irq_clr;
  logic [N-1:0]  cnt;
  logic          busy;
  logic          tick;
  logic          irq;
  logic [1:0]    state;

  int total = 0;
  int bad   = 0;
  int ec    = 0;   // number of rising edges seen by the bench
  int e0    = 0;
  int tcnt  = 0;
  int sb[$];       // rising-edge numbers after which tick must be high

  timer_ctrl #(.N(N), .PW(PW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .period   (period),
    .prescale (prescale),
    .irq_clr  (irq_clr),
    .cnt      (cnt),
    .busy     (busy),
    .tick     (tick),
    .irq      (irq),
    .state    (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: rising edge, then sample at the falling edge and check tick against the queue.
  task automatic clk();
    logic exp_t;
    @(posedge clock);
    @(negedge clock);
    ec++;
    exp_t = 1'b0;
    if (sb.size() > 0 && sb[0] == ec) begin
      exp_t = 1'b1;
      void'(sb.pop_front());
    end
    chk("tick", {31'd0, tick}, {31'd0, exp_t});
  endtask

  task automatic push_ticks(input int base, input int per, input int n);
    for (int i = 1; i <= n; i++) sb.push_back(base + i * per);
  endtask

  task automatic do_start(input int p, input int s, input logic m);
    period   = p[N-1:0];
    prescale = s[PW-1:0];
    periodic = m;
    start    = 1'b1;
    clk();
    start    = 1'b0;
    e0       = ec;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; periodic = 1'b0;
    period = '0; prescale = '0; irq_clr = 1'b0;

    // Reset
    clk(); clk();
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    clk();

    // One-shot, period 3, no prescale
    do_start(3, 0, 1'b0);
    push_ticks(e0, 4, 1);
    chk("os_cnt0", 32'(cnt), 0);
    chk("os_state_run", 32'(state), 1);
    chk("os_busy_run", 32'(busy), 1);
    for (int k = 1; k <= 3; k++) begin
      clk();
      chk("os_cnt", 32'(cnt), 32'(k));
      chk("os_state", 32'(state), 1);
    end
    clk();
    chk("os_done_state", 32'(state), 2);
    chk("os_done_busy", 32'(busy), 0);
    chk("os_done_cnt", 32'(cnt), 3);
    chk("os_irq", 32'(irq), 1);
    for (int k = 0; k < 4; k++) begin
      clk();
      chk("os_hold_cnt", 32'(cnt), 3);
      chk("os_hold_state", 32'(state), 2);
    end
    irq_clr = 1'b1;
    clk();
    irq_clr = 1'b0;
    chk("irq_clr", 32'(irq), 0);

    // Periodic, period 2, prescale 1: tick every 6 clocks
    do_start(2, 1, 1'b1);
    push_ticks(e0, 6, 3);
    tcnt = 0;
    for (int k = 1; k <= 18; k++) begin
      clk();
      if (tick === 1'b1) tcnt++;
      chk("per_cnt", 32'(cnt), 32'((k / 2) % 3));
    end
    chk("per_tick_count", 32'(tcnt), 3);
    // tick is visible now; a clear in this cycle must lose to the set
    irq_clr = 1'b1;
    clk();
    irq_clr = 1'b0;
    chk("irq_set_wins", 32'(irq), 1);
    irq_clr = 1'b1;
    clk();
    irq_clr = 1'b0;
    chk("irq_clr2", 32'(irq), 0);
    stop = 1'b1;
    clk();
    stop = 1'b0;
    chk("per_stop_state", 32'(state), 0);
    chk("per_stop_cnt", 32'(cnt), 1);

    // Degenerate: period 0, prescale 0 -> tick every clock, cnt stays 0
    do_start(0, 0, 1'b1);
    push_ticks(e0, 1, 8);
    for (int k = 1; k <= 8; k++) begin
      clk();
      chk("deg_cnt", 32'(cnt), 0);
    end
    stop = 1'b1;
    clk();
    stop = 1'b0;
    chk("deg_stop_state", 32'(state), 0);

    // Maximum period and prescale: first tick 256 clocks after start
    do_start(15, 15, 1'b0);
    push_ticks(e0, 256, 1);
    for (int k = 1; k <= 260; k++) begin
      clk();
      if (k == 240) chk("max_cnt_240", 32'(cnt), 15);
      if (k == 255) chk("max_state_255", 32'(state), 1);
    end
    chk("max_done_state", 32'(state), 2);
    chk("max_done_cnt", 32'(cnt), 15);

    // Stop mid-run at cnt 5
    do_start(9, 0, 1'b0);
    for (int k = 1; k <= 5; k++) clk();
    chk("mid_cnt5", 32'(cnt), 5);
    stop = 1'b1;
    clk();
    stop = 1'b0;
    chk("stop_state", 32'(state), 0);
    chk("stop_cnt", 32'(cnt), 5);
    chk("stop_busy", 32'(busy), 0);
    for (int k = 0; k < 12; k++) clk();
    chk("stop_cnt_hold", 32'(cnt), 5);

    // start and stop together: stop wins
    start = 1'b1; stop = 1'b1; period = 4'd1;
    clk();
    start = 1'b0; stop = 1'b0;
    chk("ss_state", 32'(state), 0);
    chk("ss_cnt", 32'(cnt), 5);
    for (int k = 0; k < 4; k++) clk();

    // Restart during RUN at cnt 4 with a new period
    do_start(9, 0, 1'b0);
    for (int k = 1; k <= 4; k++) clk();
    chk("rs_cnt4", 32'(cnt), 4);
    do_start(2, 0, 1'b0);
    push_ticks(e0, 3, 1);
    chk("rs_cnt0", 32'(cnt), 0);
    period = 4'd7;   // ignored while running
    for (int k = 1; k <= 2; k++) begin
      clk();
      chk("rs_cnt", 32'(cnt), 32'(k));
    end
    clk();
    chk("rs_done_state", 32'(state), 2);
    chk("rs_done_cnt", 32'(cnt), 2);

    // Async reset mid-run at cnt 2, between clock edges
    do_start(9, 0, 1'b1);
    clk(); clk();
    chk("ar_cnt2", 32'(cnt), 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_cnt", 32'(cnt), 0);
    chk("ar_state", 32'(state), 0);
    chk("ar_irq", 32'(irq), 0);
    chk("ar_busy", 32'(busy), 0);
    clk();
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) clk();
    chk("ar_idle_state", 32'(state), 0);
    chk("ar_idle_cnt", 32'(cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Programmable sequencer for the free-running N-bit up-counter datapath: turns it into a start/stop timer with a period compare, a clock prescaler and one-shot or periodic modes.
- Produces a one-cycle terminal tick and a sticky interrupt for software or the test harness.
- Sits between a control/register interface and the counter. It owns the count register internally and exports the count for observation.

Parameters:
- N, 8, count and period width in bits.
- PW, 4, prescaler width in bits. The counter advances once every (prescale+1) clocks.

Ports:
- clock  input  1  system clock, all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  pulse: latch configuration, clear the count, enter RUN.
- stop  input  1  pulse: leave RUN/DONE, enter IDLE, freeze cnt.
- periodic  input  1  mode, sampled at start: 1 = auto-reload, 0 = one-shot.
- period  input  N  terminal count, sampled at start.
- prescale  input  PW  clock divider value, sampled at start.
- irq_clr  input  1  clears irq.
- cnt  output  N  current count value.
- busy  output  1  1 while in RUN.
- tick  output  1  one-cycle pulse on a terminal-count event.
- irq  output  1  sticky flag, set by tick.
- state  output  2  IDLE=00, RUN=01, DONE=10 (11 unused).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; cnt=0; tick=0; irq=0; busy=0.
  - Internal prescale counter pc=0; latched period_q, prescale_q and periodic_q = 0.
  - Asserting reset mid-operation aborts immediately. No tick is emitted.
- Configuration latch: period, prescale and periodic are sampled only on an accepted start. Input changes during RUN are ignored.
- Priority per edge: reset_n > stop > start > counting.
- start, accepted in any state (in RUN it restarts):
  - cnt<=0, pc<=0, latch configuration, state<=RUN.
  - tick is not generated on the start edge.
- stop in any state: state<=IDLE, pc<=0, cnt holds its value. start and stop in the same cycle: stop wins.
- RUN, per edge:
  - If pc!=prescale_q: pc<=pc+1.
  - Otherwise, pc<=0 and an advance occurs.
- Advance:
  - If cnt!=period_q: cnt<=cnt+1.
  - If cnt==period_q (terminal), tick is asserted in the following cycle for exactly one cycle, and irq<=1.
  - periodic_q=1: cnt<=0, remain in RUN.
  - periodic_q=0: cnt holds at period_q, state<=DONE.
- Period of ticks (periodic mode): (period_q+1)*(prescale_q+1) clocks.
- period_q=0: the terminal condition is met on every advance. A tick fires every prescale_q+1 clocks and cnt stays 0.
- Max values: period_q=2^N-1 and prescale_q=2^PW-1 are legal. cnt never exceeds period_q, so no wrap past 2^N-1 is possible.
- DONE: busy=0, cnt frozen, no further ticks. Only start (re-arm) or stop (to IDLE) leave DONE.
- IDLE: no counting and no ticks. cnt holds its last value.
- irq:
  - Set on tick, cleared by irq_clr.
  - Set and clear in the same cycle: set wins, irq stays 1.
  - irq is unaffected by stop and start.
- busy = (state==RUN), combinational from the state register.
- Outputs are registered except busy. There is no combinational path from inputs to outputs.

Test Plan:
- Reset and one-shot: hold reset_n=0 for 2 cycles, then check cnt=0, state=00, irq=0. Pulse start with period=3, prescale=0, periodic=0 -> cnt 0,1,2,3 on successive edges; one tick pulse the cycle after the advance at cnt=3; state=10; busy=0; cnt holds 3; irq=1.
- Periodic with prescale: period=2, prescale=1, periodic=1 -> cnt changes every 2 clocks (0,0,1,1,2,2,0...). tick every 6 clocks, single-cycle. Three ticks observed in 18 clocks.
- Degenerate values: period=0, prescale=0, periodic=1 -> tick high every clock from the 2nd cycle after start, cnt=0 throughout. Then period=15, prescale=15 (N=4, PW=4) -> first tick 256 clocks after start.
- Control conflicts:
  - stop mid-run at cnt=5 -> state=00, cnt stays 5, no tick.
  - start and stop in the same cycle -> IDLE.
  - start during RUN at cnt=4 -> cnt=0, new period takes effect.
- irq handling: pulse irq_clr -> irq=0. Assert irq_clr on the same cycle as tick -> irq remains 1.
- Async reset mid-run: pull reset_n low between clock edges at cnt=2 -> cnt=0 and state=00 immediately without a clock edge; no tick afterwards until the next start.
